gelato_ifetch: RTL and testbench
================================

# gelato_ifetch

Instruction-fetch unit: the slave end of the fetch-scheduler → I-Fetch handshake. It accepts one selected PC per transaction, reads the 32-bit instruction from the instruction memory port, and presents the instruction with its PC, warp number and split-table number to decode. It sits between the fetch scheduler and the decoder, and has a single outstanding fetch at any time.

## Interface
- ADDR_WIDTH, 32: PC / instruction-memory address width.
- INST_WIDTH, 32: instruction width.
- WARP_NUM_WIDTH, 5: warp number width.
- SPLIT_NUM_WIDTH, 5: split-table entry number width.

- clk  in  1  clock; every flop is rising-edge triggered.
- rst_n  in  1  reset: asynchronous assert, active-low.
- fs_ready  out  1  ready toward the fetch scheduler.
- fs_valid  in  1  PC valid from the fetch scheduler.
- fs_pc  in  ADDR_WIDTH  selected PC.
- fs_warp_num  in  WARP_NUM_WIDTH  warp of the selected PC.
- fs_split_num  in  SPLIT_NUM_WIDTH  split-table entry of the selected PC.
- flush  in  1  discard any in-flight fetch.
- imem_req_valid  out  1  memory read request.
- imem_req_addr  out  ADDR_WIDTH  request address.
- imem_req_ready  in  1  memory accepts the request.
- imem_rsp_valid  in  1  read data valid.
- imem_rsp_data  in  INST_WIDTH  read data.
- dec_valid  out  1  instruction valid toward decode.
- dec_ready  in  1  decode accepts the instruction.
- dec_inst  out  INST_WIDTH  instruction.
- dec_pc, dec_warp_num, dec_split_num  out  ADDR_WIDTH / WARP_NUM_WIDTH / SPLIT_NUM_WIDTH  latched context.
- dec_fault  out  1  misaligned-PC fault; dec_inst is 0 when this is set.

## Operation
- States: IDLE, REQ, WAIT, OUT, DRAIN. Reset state is IDLE.
- IDLE:
  - fs_ready = 1.
  - On fs_valid && fs_ready: latch pc, warp_num and split_num.
  - If pc[1:0] != 0: set fault, set inst = 0, go to OUT.
  - Otherwise go to REQ.
- REQ:
  - imem_req_valid = 1 and imem_req_addr = latched pc. Both are held stable until accepted.
  - On imem_req_ready, go to WAIT.
- WAIT:
  - On imem_rsp_valid, latch imem_rsp_data into inst and go to OUT.
  - A response arriving in the same cycle as the request acceptance is not legal. The memory delivers the response at least one cycle later.
- OUT:
  - dec_valid = 1. All dec_* outputs are held stable until the cycle in which dec_ready = 1.
  - After that cycle, go to IDLE.
- fs_ready is 1 only in IDLE. There is no bypass, so the peak rate is one fetch per 4 cycles.
- flush takes priority over every other transition:
  - IDLE: any handshake in that cycle is ignored (fs_ready is forced to 0 while flush = 1); stay in IDLE.
  - REQ: if imem_req_ready is also 1, the request was accepted, so go to DRAIN. Otherwise drop the request and go to IDLE.
  - WAIT: if imem_rsp_valid is also 1, discard the data and go to IDLE. Otherwise go to DRAIN.
  - OUT: drop dec_valid and go to IDLE, even if dec_ready = 1 in the same cycle. The instruction is treated as not delivered.
  - DRAIN: stay in DRAIN.
- DRAIN: the memory response is swallowed, then the block goes to IDLE. No dec_valid is produced for it.
- Reset values: fs_ready = 0 while rst_n = 0 and 1 once rst_n is 1 (IDLE). imem_req_valid = 0, imem_req_addr = 0, dec_valid = 0, dec_fault = 0, dec_inst = 0, dec_pc = 0, dec_warp_num = 0, dec_split_num = 0.
- Reset asserted mid-operation: return to IDLE and abandon the outstanding memory response. The memory interface resets together with this block.

## Timing
- Cycle 0: fs handshake.
- Cycle 1: imem_req_valid = 1. With imem_req_ready = 1, the request is accepted in cycle 1.
- Earliest response is cycle 2. dec_valid rises in cycle 3.
- With dec_ready = 1, fs_ready rises in cycle 4.
- Fault path: dec_valid in cycle 1, and the memory port is never driven.
- All outputs are registered or decoded only from state and registers. There is no combinational path from any input to any output, except fs_ready depending on flush.

## Test plan
- Basic fetch: pc = 0x100, warp = 3, split = 7. Memory has zero wait and 1-cycle latency, data 0xDEADBEEF. Expect imem_req_addr = 0x100 in cycle 1; dec_valid in cycle 3 with inst = 0xDEADBEEF, pc = 0x100, warp = 3, split = 7; fs_ready back in cycle 4.
- Backpressure: imem_req_ready held 0 for 3 cycles, then dec_ready held 0 for 5 cycles. Expect imem_req_valid and imem_req_addr stable throughout, dec_* stable throughout, fs_ready = 0 the whole time, and exactly one decode transfer.
- Misaligned PC: pc = 0x102. Expect imem_req_valid never asserted; dec_valid in cycle 1 with dec_fault = 1 and dec_inst = 0.
- Flush in WAIT: flush pulses 1 cycle after the request is accepted, and the response arrives 3 cycles later. Expect DRAIN, no dec_valid, fs_ready = 1 the cycle after the response, and a following fetch of 0x200 to return the correct data.
- Flush coincident with events: flush together with dec_ready in OUT, then flush together with imem_req_ready in REQ. Expect no transfer counted at decode, DRAIN entered for the second case, and no lost or duplicate instruction.
- Reset mid-WAIT: deassert rst_n asynchronously. Expect all outputs at their reset values immediately, and dec_valid never asserted for the abandoned fetch.

Source files
------------

// File: rtl/gelato_ifetch.sv
// rtl/gelato_ifetch.sv - instruction-fetch unit between the fetch scheduler and decode
// One fetch in flight at a time; a flushed request whose response is still owed is swallowed in DRAIN.
module gelato_ifetch #(
  parameter int ADDR_WIDTH      = 32,
  parameter int INST_WIDTH      = 32,
  parameter int WARP_NUM_WIDTH  = 5,
  parameter int SPLIT_NUM_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,

  output logic                       fs_ready,
  input  logic                       fs_valid,
  input  logic [ADDR_WIDTH-1:0]      fs_pc,
  input  logic [WARP_NUM_WIDTH-1:0]  fs_warp_num,
  input  logic [SPLIT_NUM_WIDTH-1:0] fs_split_num,
  input  logic                       flush,

  output logic                       imem_req_valid,
  output logic [ADDR_WIDTH-1:0]      imem_req_addr,
  input  logic                       imem_req_ready,
  input  logic                       imem_rsp_valid,
  input  logic [INST_WIDTH-1:0]      imem_rsp_data,

  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [INST_WIDTH-1:0]      dec_inst,
  output logic [ADDR_WIDTH-1:0]      dec_pc,
  output logic [WARP_NUM_WIDTH-1:0]  dec_warp_num,
  output logic [SPLIT_NUM_WIDTH-1:0] dec_split_num,
  output logic                       dec_fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      pc_q, pc_d;
  logic [WARP_NUM_WIDTH-1:0]  warp_q, warp_d;
  logic [SPLIT_NUM_WIDTH-1:0] split_q, split_d;
  logic [INST_WIDTH-1:0]      inst_q, inst_d;
  logic                       fault_q, fault_d;

  logic fs_hs;
  logic misaligned;

  // fs_ready is the only output allowed to see an input (flush) combinationally.
  assign fs_ready   = rst_n && (state_q == S_IDLE) && !flush;
  assign fs_hs      = fs_valid && fs_ready;
  assign misaligned = (fs_pc[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    warp_d  = warp_q;
    split_d = split_q;
    inst_d  = inst_q;
    fault_d = fault_q;

    unique case (state_q)
      S_IDLE: begin
        if (fs_hs) begin
          pc_d    = fs_pc;
          warp_d  = fs_warp_num;
          split_d = fs_split_num;
          if (misaligned) begin
            fault_d = 1'b1;
            inst_d  = '0;
            state_d = S_OUT;
          end else begin
            fault_d = 1'b0;
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        // An accepted request still owes a response, so a flush must wait it out.
        if (flush) begin
          state_d = imem_req_ready ? S_DRAIN : S_IDLE;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (flush) begin
          state_d = imem_rsp_valid ? S_IDLE : S_DRAIN;
        end else if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = S_OUT;
        end
      end

      S_OUT: begin
        if (flush || dec_ready) begin
          state_d = S_IDLE;
        end
      end

      S_DRAIN: begin
        if (!flush && imem_rsp_valid) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      warp_q  <= '0;
      split_q <= '0;
      inst_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      warp_q  <= warp_d;
      split_q <= split_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = imem_req_valid ? pc_q : '0;

  assign dec_valid     = (state_q == S_OUT);
  assign dec_inst      = inst_q;
  assign dec_pc        = pc_q;
  assign dec_warp_num  = warp_q;
  assign dec_split_num = split_q;
  assign dec_fault     = fault_q;

endmodule

// File: tb/tb_gelato_ifetch.sv
// tb/tb_gelato_ifetch.sv - self-checking bench for gelato_ifetch
// Vector table, hand-timed flush/reset sequences and a random phase scored against a transaction queue.
`timescale 1ns/1ps
module tb_gelato_ifetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fs_ready;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [4:0]  fs_warp_num;
  logic [4:0]  fs_split_num;
  logic        flush;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [4:0]  dec_warp_num;
  logic [4:0]  dec_split_num;
  logic        dec_fault;

  always #5 clk = ~clk;

  gelato_ifetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fs_ready       (fs_ready),
    .fs_valid       (fs_valid),
    .fs_pc          (fs_pc),
    .fs_warp_num    (fs_warp_num),
    .fs_split_num   (fs_split_num),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .dec_warp_num   (dec_warp_num),
    .dec_split_num  (dec_split_num),
    .dec_fault      (dec_fault)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  // Memory: one request at a time, response mem_lat cycles after acceptance.
  int          mem_lat;
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_busy <= 1'b0;
      mem_cnt  <= 0;
      mem_addr <= '0;
    end else if (imem_req_valid && imem_req_ready) begin
      mem_busy <= 1'b1;
      mem_cnt  <= mem_lat;
      mem_addr <= imem_req_addr;
    end else if (mem_busy) begin
      if (mem_cnt == 1) mem_busy <= 1'b0;
      else              mem_cnt  <= mem_cnt - 1;
    end
  end

  assign imem_rsp_valid = mem_busy && (mem_cnt == 1);
  assign imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : 32'hBAD00BAD;

  // Transaction-level reference: a fetch accepted from the scheduler must reach decode exactly once unless flushed.
  typedef struct {
    logic [31:0] pc;
    logic [4:0]  warp;
    logic [4:0]  split;
    logic [31:0] inst;
    logic        fault;
  } txn_t;

  txn_t q[$];
  int   n_hs   = 0;
  int   n_xfer = 0;

  always @(negedge clk) begin
    txn_t t;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (fs_ready) chk("idle_mem_quiet", mem_busy, 0);
      if (imem_req_valid && imem_req_ready) begin
        chk("req_single", mem_busy, 0);
        chk("req_has_txn", q.size(), 1);
        if (q.size() > 0) chk("req_addr_model", imem_req_addr, q[0].pc);
        chk("req_aligned", imem_req_addr[1:0], 0);
      end
      if (dec_valid) chk("dec_has_txn", q.size(), 1);
      if (flush) begin
        q.delete();
      end else if (dec_valid && dec_ready && q.size() > 0) begin
        t = q.pop_front();
        chk("sb_inst",  dec_inst,      t.inst);
        chk("sb_pc",    dec_pc,        t.pc);
        chk("sb_warp",  dec_warp_num,  t.warp);
        chk("sb_split", dec_split_num, t.split);
        chk("sb_fault", dec_fault,     t.fault);
        n_xfer++;
      end
      if (fs_valid && fs_ready) begin
        chk("single_outstanding", q.size(), 0);
        t.pc    = fs_pc;
        t.warp  = fs_warp_num;
        t.split = fs_split_num;
        t.fault = (fs_pc[1:0] != 2'b00);
        t.inst  = t.fault ? 32'h0 : mem_word(fs_pc);
        q.push_back(t);
        n_hs++;
      end
    end
  end

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  warp;
    logic [4:0]  split;
    int          lat;
    int          w;
    int          dw;
    int          exp_lat;
    logic        exp_fault;
    logic [31:0] exp_inst;
  } vec_t;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_fs_ready"}, fs_ready, 0);
    chk({tag, "_req_valid"}, imem_req_valid, 0);
    chk({tag, "_req_addr"}, imem_req_addr, 0);
    chk({tag, "_dec_valid"}, dec_valid, 0);
    chk({tag, "_dec_fault"}, dec_fault, 0);
    chk({tag, "_dec_inst"}, dec_inst, 0);
    chk({tag, "_dec_pc"}, dec_pc, 0);
    chk({tag, "_dec_warp"}, dec_warp_num, 0);
    chk({tag, "_dec_split"}, dec_split_num, 0);
  endtask

  // Cycle 0 is the scheduler handshake; w = request stall cycles, dw = decode stall cycles.
  task automatic do_fetch(input vec_t v);
    int c;
    bit got;
    int x0;
    x0 = n_xfer;
    cyc();
    fs_valid = 1'b1; fs_pc = v.pc; fs_warp_num = v.warp; fs_split_num = v.split;
    flush = 1'b0; dec_ready = 1'b0; imem_req_ready = (v.w == 0); mem_lat = v.lat;
    @(negedge clk);
    chk("fetch_hs_ready", fs_ready, 1);
    c = 0;
    got = 1'b0;
    while (!got && c < 40) begin
      cyc();
      c++;
      fs_valid = 1'b0;
      imem_req_ready = (c >= v.w + 1);
      dec_ready = (v.dw == 0);
      @(negedge clk);
      if (dec_valid) begin
        got = 1'b1;
      end else begin
        chk("fetch_busy_ready", fs_ready, 0);
        if (v.exp_fault || c > v.w + 1) begin
          chk("req_idle", imem_req_valid, 0);
        end else begin
          chk("req_valid_held", imem_req_valid, 1);
          chk("req_addr_held", imem_req_addr, v.pc);
        end
      end
    end
    chk("dec_latency", c, v.exp_lat);
    for (int k = 0; k <= v.dw; k++) begin
      if (k > 0) begin
        cyc();
        dec_ready = (k == v.dw);
        @(negedge clk);
      end
      chk("dec_valid_held", dec_valid, 1);
      chk("dec_inst", dec_inst, v.exp_inst);
      chk("dec_pc", dec_pc, v.pc);
      chk("dec_warp", dec_warp_num, v.warp);
      chk("dec_split", dec_split_num, v.split);
      chk("dec_fault", dec_fault, v.exp_fault);
      chk("dec_fs_ready_low", fs_ready, 0);
    end
    cyc();
    dec_ready = 1'b0;
    imem_req_ready = 1'b0;
    @(negedge clk);
    chk("fs_ready_back", fs_ready, 1);
    chk("dec_valid_drop", dec_valid, 0);
    chk("one_transfer", n_xfer - x0, 1);
  endtask

  function automatic vec_t mkv(input logic [31:0] pc, input logic [4:0] warp, input logic [4:0] split,
                               input int lat, input int w, input int dw, input int exp_lat,
                               input logic exp_fault, input logic [31:0] exp_inst);
    vec_t v;
    v.pc = pc; v.warp = warp; v.split = split; v.lat = lat; v.w = w; v.dw = dw;
    v.exp_lat = exp_lat; v.exp_fault = exp_fault; v.exp_inst = exp_inst;
    return v;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   x0;
    int   h0;

    rst_n = 1'b0; fs_valid = 1'b0; fs_pc = '0; fs_warp_num = '0; fs_split_num = '0;
    flush = 1'b0; imem_req_ready = 1'b0; dec_ready = 1'b0; mem_lat = 1;

    vecs[0] = mkv(32'h0000_0100, 5'd3,  5'd7,  1, 0, 0, 3, 1'b0, 32'hDEADBEEF);
    vecs[1] = mkv(32'h0000_0104, 5'd1,  5'd2,  1, 3, 5, 6, 1'b0, mem_word(32'h104));
    vecs[2] = mkv(32'h0000_0102, 5'd9,  5'd4,  1, 0, 0, 1, 1'b1, 32'h0);
    vecs[3] = mkv(32'h0000_0203, 5'd31, 5'd31, 1, 0, 2, 1, 1'b1, 32'h0);
    vecs[4] = mkv(32'hFFFF_FFFC, 5'd0,  5'd31, 2, 1, 1, 5, 1'b0, mem_word(32'hFFFF_FFFC));
    vecs[5] = mkv(32'h0000_1000, 5'd17, 5'd0,  3, 0, 0, 5, 1'b0, mem_word(32'h1000));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_fs_ready_up", fs_ready, 1);
    chk("rst_dec_idle", dec_valid, 0);

    for (int i = 0; i < 6; i++) do_fetch(vecs[i]);

    // Flush in WAIT; response lands three cycles later while draining.
    x0 = n_xfer;
    cyc(); fs_valid = 1'b1; fs_pc = 32'h180; fs_warp_num = 5'd2; fs_split_num = 5'd5;
    imem_req_ready = 1'b1; mem_lat = 4; @(negedge clk);
    cyc(); fs_valid = 1'b0; @(negedge clk);
    chk("fw_req", imem_req_valid, 1);
    cyc(); flush = 1'b1; @(negedge clk);
    chk("fw_ready_masked", fs_ready, 0);
    for (int k = 3; k <= 5; k++) begin
      cyc(); flush = 1'b0; imem_req_ready = 1'b0; @(negedge clk);
      chk("fw_drain_ready", fs_ready, 0);
      chk("fw_drain_dec", dec_valid, 0);
      chk("fw_drain_req", imem_req_valid, 0);
    end
    cyc(); @(negedge clk);
    chk("fw_ready_after", fs_ready, 1);
    chk("fw_dec_after", dec_valid, 0);
    chk("fw_no_xfer", n_xfer - x0, 0);
    do_fetch(mkv(32'h200, 5'd8, 5'd3, 1, 0, 0, 3, 1'b0, mem_word(32'h200)));

    // Flush together with dec_ready in OUT.
    x0 = n_xfer;
    cyc(); fs_valid = 1'b1; fs_pc = 32'h300; fs_warp_num = 5'd6; fs_split_num = 5'd1;
    imem_req_ready = 1'b1; mem_lat = 1; dec_ready = 1'b0; @(negedge clk);
    cyc(); fs_valid = 1'b0; @(negedge clk);
    cyc(); @(negedge clk);
    cyc(); flush = 1'b1; dec_ready = 1'b1; @(negedge clk);
    chk("fo_dec_valid", dec_valid, 1);
    chk("fo_ready_masked", fs_ready, 0);
    cyc(); flush = 1'b0; dec_ready = 1'b0; imem_req_ready = 1'b0; @(negedge clk);
    chk("fo_dec_drop", dec_valid, 0);
    chk("fo_idle", fs_ready, 1);
    chk("fo_no_xfer", n_xfer - x0, 0);

    // Flush together with imem_req_ready in REQ.
    cyc(); fs_valid = 1'b1; fs_pc = 32'h304; imem_req_ready = 1'b0; mem_lat = 2; @(negedge clk);
    cyc(); fs_valid = 1'b0; flush = 1'b1; imem_req_ready = 1'b1; @(negedge clk);
    chk("fr_req", imem_req_valid, 1);
    for (int k = 2; k <= 3; k++) begin
      cyc(); flush = 1'b0; imem_req_ready = 1'b0; @(negedge clk);
      chk("fr_drain_ready", fs_ready, 0);
      chk("fr_drain_dec", dec_valid, 0);
      chk("fr_drain_req", imem_req_valid, 0);
    end
    cyc(); @(negedge clk);
    chk("fr_ready_after", fs_ready, 1);
    chk("fr_no_xfer", n_xfer - x0, 0);
    do_fetch(mkv(32'h308, 5'd11, 5'd12, 1, 0, 0, 3, 1'b0, mem_word(32'h308)));

    // Flush in REQ without acceptance, then flush over a scheduler handshake in IDLE.
    cyc(); fs_valid = 1'b1; fs_pc = 32'h30C; imem_req_ready = 1'b0; @(negedge clk);
    cyc(); fs_valid = 1'b0; flush = 1'b1; @(negedge clk);
    chk("fq_req", imem_req_valid, 1);
    cyc(); flush = 1'b0; @(negedge clk);
    chk("fq_idle", fs_ready, 1);
    chk("fq_req_drop", imem_req_valid, 0);
    cyc(); fs_valid = 1'b1; fs_pc = 32'h310; flush = 1'b1; @(negedge clk);
    chk("fi_ready_masked", fs_ready, 0);
    cyc(); fs_valid = 1'b0; flush = 1'b0; @(negedge clk);
    chk("fi_no_req", imem_req_valid, 0);
    chk("fi_no_dec", dec_valid, 0);
    chk("fi_ready", fs_ready, 1);

    // Asynchronous reset while waiting on memory.
    cyc(); fs_valid = 1'b1; fs_pc = 32'h400; fs_warp_num = 5'd4; fs_split_num = 5'd9;
    imem_req_ready = 1'b1; mem_lat = 6; @(negedge clk);
    cyc(); fs_valid = 1'b0; @(negedge clk);
    chk("rm_req", imem_req_valid, 1);
    cyc(); @(negedge clk);
    chk("rm_wait_dec", dec_valid, 0);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_mid");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    imem_req_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rm_no_dec", dec_valid, 0);
      chk("rm_idle", fs_ready, 1);
    end
    do_fetch(mkv(32'h404, 5'd4, 5'd9, 2, 0, 0, 4, 1'b0, mem_word(32'h404)));

    // Random traffic without flush, scored by the transaction queue.
    x0 = n_xfer;
    h0 = n_hs;
    for (int cy = 0; cy < 500; cy++) begin
      cyc();
      fs_valid       = ($urandom_range(0, 1) == 1);
      fs_pc          = {22'h0, 8'($urandom_range(0, 255)),
                        ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
      fs_warp_num    = 5'($urandom);
      fs_split_num   = 5'($urandom);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      dec_ready      = ($urandom_range(0, 9) < 6);
      mem_lat        = $urandom_range(1, 3);
      @(negedge clk);
    end
    cyc();
    fs_valid = 1'b0; dec_ready = 1'b1; imem_req_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 60 && q.size() != 0; k++) begin
      cyc();
      @(negedge clk);
    end
    chk("rand_drained", q.size(), 0);
    chk("rand_hs_eq_xfer", n_hs - h0, n_xfer - x0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
